// File: rtl/instruction_cache_set_assoc.sv
// instruction_cache_set_assoc
//   Set-associative, read-only instruction cache with round-robin replacement
//   and full-line refill from L2.
//
//   State       | meaning
//   ------------+----------------------------------------------------------
//   ST_IDLE     | accepting fetches, hits return data the next cycle
//   ST_MISS_REQ | line address presented to L2, waiting for its ready
//   ST_MISS_WAIT| waiting for the refill line from L2
//   ST_REPLAY   | re-look-up of the missed PC, returns the word
//   ST_FLUSH    | invalidating one set per cycle, set 0 .. SETS-1
//
// Ports
//   CLK, RST                     clock (rising edge), async active-high reset
//   STALL_INSTRUCTION_CACHE      freezes the fetch output, blocks new PCs
//   PC, PC_VALID                 fetch request (byte address)
//   FLUSH                        invalidate-all request
//   INSTRUCTION(_VALID)          fetch result
//   INSTRUCTION_CACHE_READY      a PC may be accepted this cycle
//   ADDRESS_TO_L2_*              line-address request to L2
//   DATA_FROM_L2_*               full-line refill, word 0 in the LSBs
module instruction_cache_set_assoc #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CACHE_SIZE     = 16384,
    parameter int WORD_PER_BLOCK = 16,
    parameter int WAYS           = 4,
    localparam int SETS = CACHE_SIZE / (WAYS * WORD_PER_BLOCK * DATA_WIDTH / 8),
    localparam int BO   = $clog2(DATA_WIDTH / 8),
    localparam int WO   = $clog2(WORD_PER_BLOCK),
    localparam int SO   = $clog2(SETS),
    localparam int TAG  = ADDRESS_WIDTH - SO - WO - BO,
    localparam int BA   = ADDRESS_WIDTH - WO - BO,
    localparam int LINE = WORD_PER_BLOCK * DATA_WIDTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     STALL_INSTRUCTION_CACHE,
    input  logic [ADDRESS_WIDTH-1:0] PC,
    input  logic                     PC_VALID,
    input  logic                     FLUSH,
    output logic [DATA_WIDTH-1:0]    INSTRUCTION,
    output logic                     INSTRUCTION_VALID,
    output logic                     INSTRUCTION_CACHE_READY,
    output logic                     ADDRESS_TO_L2_VALID_INS,
    input  logic                     ADDRESS_TO_L2_READY_INS,
    output logic [BA-1:0]            ADDRESS_TO_L2_INS,
    input  logic                     DATA_FROM_L2_VALID_INS,
    output logic                     DATA_FROM_L2_READY_INS,
    input  logic [LINE-1:0]          DATA_FROM_L2_INS
);

    localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int LB = $clog2(LINE);

    typedef enum logic [2:0] {
        ST_IDLE, ST_MISS_REQ, ST_MISS_WAIT, ST_REPLAY, ST_FLUSH
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDRESS_WIDTH-1:BO]  pc_q;
    logic                       flush_pend_q;
    logic [SO-1:0]              flush_set_q;

    logic [WAYS-1:0]            valid_q [SETS];
    logic [WW-1:0]              rr_q    [SETS];
    logic [TAG-1:0]             tag_q   [SETS][WAYS];
    logic [LINE-1:0]            data_q  [SETS][WAYS];

    // Byte-within-word bits never select anything.
    logic unused_byte_bits;
    assign unused_byte_bits = ^PC[BO-1:0];

    // Lookup port: the live PC in IDLE, the latched miss PC in REPLAY.
    logic [ADDRESS_WIDTH-1:BO]  lk_addr;
    logic [SO-1:0]              lk_set;
    logic [TAG-1:0]             lk_tag;
    logic [LB-1:0]              lk_bit;
    logic                       hit;
    logic [DATA_WIDTH-1:0]      hit_word;

    assign lk_addr = (state_q == ST_REPLAY) ? pc_q : PC[ADDRESS_WIDTH-1:BO];
    assign lk_set  = lk_addr[BO+WO +: SO];
    assign lk_tag  = lk_addr[ADDRESS_WIDTH-1 -: TAG];
    assign lk_bit  = {lk_addr[BO +: WO], {$clog2(DATA_WIDTH){1'b0}}};

    always_comb begin
        hit      = 1'b0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_set][w] && (tag_q[lk_set][w] == lk_tag)) begin
                hit      = 1'b1;
                hit_word = data_q[lk_set][w][lk_bit +: DATA_WIDTH];
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin way.
    logic [SO-1:0] miss_set;
    logic [WW-1:0] victim;
    logic          victim_free;

    assign miss_set = pc_q[BO+WO +: SO];

    always_comb begin
        victim      = rr_q[miss_set];
        victim_free = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[miss_set][w]) begin
                victim      = WW'(w);
                victim_free = 1'b1;
            end
        end
    end

    logic accept, start_flush, fill;

    always_comb begin
        state_d                 = state_q;
        accept                  = 1'b0;
        start_flush             = 1'b0;
        fill                    = 1'b0;
        INSTRUCTION_CACHE_READY = (state_q == ST_IDLE) && !flush_pend_q;
        ADDRESS_TO_L2_VALID_INS = (state_q == ST_MISS_REQ);
        ADDRESS_TO_L2_INS       = '0;
        DATA_FROM_L2_READY_INS  = (state_q == ST_MISS_WAIT);
        case (state_q)
            ST_IDLE: begin
                if (!STALL_INSTRUCTION_CACHE) begin
                    if (FLUSH || flush_pend_q) begin
                        start_flush = 1'b1;
                        state_d     = ST_FLUSH;
                    end else if (PC_VALID) begin
                        accept = 1'b1;
                        if (!hit) state_d = ST_MISS_REQ;
                    end
                end
            end
            ST_MISS_REQ: begin
                ADDRESS_TO_L2_INS = pc_q[ADDRESS_WIDTH-1:WO+BO];
                if (ADDRESS_TO_L2_READY_INS) state_d = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                if (DATA_FROM_L2_VALID_INS) begin
                    fill    = 1'b1;
                    state_d = ST_REPLAY;
                end
            end
            ST_REPLAY: begin
                if (!STALL_INSTRUCTION_CACHE) state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                if (flush_set_q == SO'(SETS - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q           <= ST_IDLE;
            pc_q              <= '0;
            flush_pend_q      <= 1'b0;
            flush_set_q       <= '0;
            INSTRUCTION       <= '0;
            INSTRUCTION_VALID <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q <= state_d;

            // A flush seen outside IDLE waits here until the miss completes.
            if (start_flush)
                flush_pend_q <= 1'b0;
            else if (FLUSH && (state_q != ST_FLUSH))
                flush_pend_q <= 1'b1;

            if (accept) begin
                pc_q              <= PC[ADDRESS_WIDTH-1:BO];
                INSTRUCTION_VALID <= hit;
                if (hit) INSTRUCTION <= hit_word;
            end else if ((state_q == ST_IDLE) && !STALL_INSTRUCTION_CACHE) begin
                INSTRUCTION_VALID <= 1'b0;
            end

            if ((state_q == ST_REPLAY) && !STALL_INSTRUCTION_CACHE) begin
                INSTRUCTION       <= hit_word;
                INSTRUCTION_VALID <= 1'b1;
            end

            if (start_flush) flush_set_q <= '0;
            if (state_q == ST_FLUSH) begin
                valid_q[flush_set_q] <= '0;
                rr_q[flush_set_q]    <= '0;
                flush_set_q          <= flush_set_q + SO'(1);
            end

            if (fill) begin
                valid_q[miss_set][victim] <= 1'b1;
                if (!victim_free)
                    rr_q[miss_set] <= (rr_q[miss_set] == WW'(WAYS - 1)) ? '0
                                      : rr_q[miss_set] + WW'(1);
            end
        end
    end

    // Tag and data arrays carry no reset; the valid bits qualify them.
    always_ff @(posedge CLK) begin
        if (fill) begin
            tag_q[miss_set][victim]  <= pc_q[ADDRESS_WIDTH-1 -: TAG];
            data_q[miss_set][victim] <= DATA_FROM_L2_INS;
        end
    end

endmodule

// File: tb/tb_instruction_cache_set_assoc.sv
module tb_instruction_cache_set_assoc;

    logic         CLK;
    logic         RST;
    logic         STALL_INSTRUCTION_CACHE;
    logic [31:0]  PC;
    logic         PC_VALID;
    logic         FLUSH;
    logic [31:0]  INSTRUCTION;
    logic         INSTRUCTION_VALID;
    logic         INSTRUCTION_CACHE_READY;
    logic         ADDRESS_TO_L2_VALID_INS;
    logic         ADDRESS_TO_L2_READY_INS;
    logic [25:0]  ADDRESS_TO_L2_INS;
    logic         DATA_FROM_L2_VALID_INS;
    logic         DATA_FROM_L2_READY_INS;
    logic [511:0] DATA_FROM_L2_INS;

    int total = 0;
    int bad   = 0;

    instruction_cache_set_assoc dut (
        .CLK                     (CLK),
        .RST                     (RST),
        .STALL_INSTRUCTION_CACHE (STALL_INSTRUCTION_CACHE),
        .PC                      (PC),
        .PC_VALID                (PC_VALID),
        .FLUSH                   (FLUSH),
        .INSTRUCTION             (INSTRUCTION),
        .INSTRUCTION_VALID       (INSTRUCTION_VALID),
        .INSTRUCTION_CACHE_READY (INSTRUCTION_CACHE_READY),
        .ADDRESS_TO_L2_VALID_INS (ADDRESS_TO_L2_VALID_INS),
        .ADDRESS_TO_L2_READY_INS (ADDRESS_TO_L2_READY_INS),
        .ADDRESS_TO_L2_INS       (ADDRESS_TO_L2_INS),
        .DATA_FROM_L2_VALID_INS  (DATA_FROM_L2_VALID_INS),
        .DATA_FROM_L2_READY_INS  (DATA_FROM_L2_READY_INS),
        .DATA_FROM_L2_INS        (DATA_FROM_L2_INS)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = base + 32'(i);
        return l;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(INSTRUCTION_CACHE_READY), 64'd1);
        chk({tag, "_ins"},   64'(INSTRUCTION), 64'd0);
        chk({tag, "_ivld"},  64'(INSTRUCTION_VALID), 64'd0);
        chk({tag, "_l2av"},  64'(ADDRESS_TO_L2_VALID_INS), 64'd0);
        chk({tag, "_l2dr"},  64'(DATA_FROM_L2_READY_INS), 64'd0);
        chk({tag, "_l2a"},   64'(ADDRESS_TO_L2_INS), 64'd0);
    endtask

    // Full miss: accept, address handshake, refill, replay result.
    task automatic miss_fill(input string tag, input logic [31:0] pc, input logic [31:0] base,
                             input logic [25:0] exp_addr, input logic [31:0] exp_ins);
        PC = pc; PC_VALID = 1'b1;
        cyc();
        PC_VALID = 1'b0;
        chk({tag, "_l2av"},  64'(ADDRESS_TO_L2_VALID_INS), 64'd1);
        chk({tag, "_l2a"},   64'(ADDRESS_TO_L2_INS), 64'(exp_addr));
        chk({tag, "_ivld0"}, 64'(INSTRUCTION_VALID), 64'd0);
        ADDRESS_TO_L2_READY_INS = 1'b1;
        cyc();
        ADDRESS_TO_L2_READY_INS = 1'b0;
        chk({tag, "_l2dr"}, 64'(DATA_FROM_L2_READY_INS), 64'd1);
        DATA_FROM_L2_INS = mk_line(base); DATA_FROM_L2_VALID_INS = 1'b1;
        cyc();
        DATA_FROM_L2_VALID_INS = 1'b0;
        cyc();
        chk({tag, "_ins"},  64'(INSTRUCTION), 64'(exp_ins));
        chk({tag, "_ivld"}, 64'(INSTRUCTION_VALID), 64'd1);
    endtask

    task automatic fetch_hit(input string tag, input logic [31:0] pc, input logic [31:0] exp_ins);
        PC = pc; PC_VALID = 1'b1;
        cyc();
        PC_VALID = 1'b0;
        chk({tag, "_ins"},  64'(INSTRUCTION), 64'(exp_ins));
        chk({tag, "_ivld"}, 64'(INSTRUCTION_VALID), 64'd1);
        chk({tag, "_l2av"}, 64'(ADDRESS_TO_L2_VALID_INS), 64'd0);
    endtask

    initial begin
        int n;
        RST = 1'b1;
        STALL_INSTRUCTION_CACHE = 1'b0;
        PC = '0; PC_VALID = 1'b0; FLUSH = 1'b0;
        ADDRESS_TO_L2_READY_INS = 1'b0;
        DATA_FROM_L2_VALID_INS = 1'b0;
        DATA_FROM_L2_INS = '0;

        // Reset state
        cyc(); cyc();
        chk_reset_outputs("rst");
        RST = 1'b0;
        cyc();

        // Cold miss, then hits from the same line (back to back)
        miss_fill("cold", 32'h0000_1004, 32'h0, 26'h40, 32'h1);
        PC = 32'h0000_1008; PC_VALID = 1'b1;
        cyc();
        chk("hit8_ins", 64'(INSTRUCTION), 64'h2);
        chk("hit8_ivld", 64'(INSTRUCTION_VALID), 64'd1);
        chk("hit8_l2av", 64'(ADDRESS_TO_L2_VALID_INS), 64'd0);
        PC = 32'h0000_100C;
        cyc();
        PC_VALID = 1'b0;
        chk("hitC_ins", 64'(INSTRUCTION), 64'h3);
        chk("hitC_ivld", 64'(INSTRUCTION_VALID), 64'd1);

        // Stall freezes output and blocks a pending PC
        STALL_INSTRUCTION_CACHE = 1'b1;
        PC = 32'h0000_1000; PC_VALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_ins", 64'(INSTRUCTION), 64'h3);
            chk("stall_ivld", 64'(INSTRUCTION_VALID), 64'd1);
        end
        STALL_INSTRUCTION_CACHE = 1'b0;
        cyc();
        PC_VALID = 1'b0;
        chk("unstall_ins", 64'(INSTRUCTION), 64'h0);
        chk("unstall_ivld", 64'(INSTRUCTION_VALID), 64'd1);
        cyc();
        chk("idle_ivld", 64'(INSTRUCTION_VALID), 64'd0);

        // Flush from IDLE: READY low exactly 64 cycles, same-cycle PC ignored
        FLUSH = 1'b1; PC = 32'h0000_1008; PC_VALID = 1'b1;
        cyc();
        FLUSH = 1'b0; PC_VALID = 1'b0;
        chk("flush_ivld", 64'(INSTRUCTION_VALID), 64'd0);
        chk("flush_l2av", 64'(ADDRESS_TO_L2_VALID_INS), 64'd0);
        n = 0;
        while (!INSTRUCTION_CACHE_READY && n < 200) begin
            n++;
            cyc();
        end
        chk("flush_len", 64'(n), 64'd64);
        miss_fill("postflush", 32'h0000_1004, 32'h500, 26'h40, 32'h501);

        // Flush during MISS_WAIT is serviced after REPLAY
        PC = 32'h0000_2000; PC_VALID = 1'b1;
        cyc();
        PC_VALID = 1'b0;
        chk("fmw_l2a", 64'(ADDRESS_TO_L2_INS), 64'h80);
        ADDRESS_TO_L2_READY_INS = 1'b1;
        cyc();
        ADDRESS_TO_L2_READY_INS = 1'b0;
        FLUSH = 1'b1;
        cyc();
        FLUSH = 1'b0;
        chk("fmw_wait_dr", 64'(DATA_FROM_L2_READY_INS), 64'd1);
        DATA_FROM_L2_INS = mk_line(32'h700); DATA_FROM_L2_VALID_INS = 1'b1;
        cyc();
        DATA_FROM_L2_VALID_INS = 1'b0;
        cyc();
        chk("fmw_replay_ins", 64'(INSTRUCTION), 64'h700);
        chk("fmw_replay_ivld", 64'(INSTRUCTION_VALID), 64'd1);
        cyc();
        n = 0;
        while (!INSTRUCTION_CACHE_READY && n < 200) begin
            n++;
            cyc();
        end
        chk("fmw_flush_len", 64'(n >= 64 && n < 200), 64'd1);

        // 0x1004 was flushed: miss, and L2 ready held low for 5 cycles
        PC = 32'h0000_1004; PC_VALID = 1'b1;
        cyc();
        PC_VALID = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("hold_l2av", 64'(ADDRESS_TO_L2_VALID_INS), 64'd1);
            chk("hold_l2a", 64'(ADDRESS_TO_L2_INS), 64'h40);
            cyc();
        end
        chk("hold6_l2av", 64'(ADDRESS_TO_L2_VALID_INS), 64'd1);
        chk("hold6_l2a", 64'(ADDRESS_TO_L2_INS), 64'h40);
        ADDRESS_TO_L2_READY_INS = 1'b1;
        cyc();
        ADDRESS_TO_L2_READY_INS = 1'b0;
        chk("hold_done_l2av", 64'(ADDRESS_TO_L2_VALID_INS), 64'd0);
        chk("hold_wait_dr", 64'(DATA_FROM_L2_READY_INS), 64'd1);

        // Reset in MISS_WAIT: outputs return at once, late data ignored
        RST = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        #1;
        RST = 1'b0;
        DATA_FROM_L2_INS = mk_line(32'h800); DATA_FROM_L2_VALID_INS = 1'b1;
        cyc();
        chk("late_dr", 64'(DATA_FROM_L2_READY_INS), 64'd0);
        DATA_FROM_L2_VALID_INS = 1'b0;
        miss_fill("refetch", 32'h0000_1004, 32'h900, 26'h40, 32'h901);

        // Replacement: fill all four ways of set 0, then evict round-robin
        RST = 1'b1;
        #2;
        RST = 1'b0;
        cyc();
        miss_fill("w0", 32'h0000_0000, 32'hA00, 26'h000, 32'hA00);
        miss_fill("w1", 32'h0000_1000, 32'hB00, 26'h040, 32'hB00);
        miss_fill("w2", 32'h0000_2000, 32'hC00, 26'h080, 32'hC00);
        miss_fill("w3", 32'h0000_3000, 32'hD00, 26'h0C0, 32'hD00);
        miss_fill("ev0", 32'h0000_4000, 32'hE00, 26'h100, 32'hE00);
        fetch_hit("h1000", 32'h0000_1000, 32'hB00);
        fetch_hit("h2004", 32'h0000_2004, 32'hC01);
        fetch_hit("h4008", 32'h0000_4008, 32'hE02);
        miss_fill("ev1", 32'h0000_0000, 32'hF00, 26'h000, 32'hF00);
        fetch_hit("h3000", 32'h0000_3000, 32'hD00);
        fetch_hit("h0004", 32'h0000_0004, 32'hF01);
        miss_fill("re1000", 32'h0000_1000, 32'h1100, 26'h040, 32'h1100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_cache_set_assoc.md
INSTRUCTION_CACHE_SET_ASSOC -- requirements
Module: instruction_cache_set_assoc

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-003 SHALL have parameter CACHE_SIZE, default 16384, total data bytes.
REQ-004 SHALL have parameter WORD_PER_BLOCK, default 16, words per line (power of 2).
REQ-005 SHALL have parameter WAYS, default 4, associativity (power of 2, 1..8).
REQ-006 SHALL derive SETS=CACHE_SIZE/(WAYS*WORD_PER_BLOCK*DATA_WIDTH/8); BO=log2(DATA_WIDTH/8), WO=log2(WORD_PER_BLOCK), SO=log2(SETS), TAG=ADDRESS_WIDTH-SO-WO-BO, BA=ADDRESS_WIDTH-WO-BO.
REQ-007 SHALL have CLK  in  1  sole clock, rising edge.
REQ-008 SHALL have RST  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have STALL_INSTRUCTION_CACHE  in  1  pipeline stall.
REQ-010 SHALL have PC / PC_VALID  in  ADDRESS_WIDTH / 1  fetch request.
REQ-011 SHALL have FLUSH  in  1  invalidate-all request.
REQ-012 SHALL have INSTRUCTION / INSTRUCTION_VALID  out  DATA_WIDTH / 1  fetch result.
REQ-013 SHALL have INSTRUCTION_CACHE_READY  out  1  PC may be accepted.
REQ-014 SHALL have ADDRESS_TO_L2_VALID_INS out 1, ADDRESS_TO_L2_READY_INS in 1, ADDRESS_TO_L2_INS out BA: line-address request to L2.
REQ-015 SHALL have DATA_FROM_L2_VALID_INS in 1, DATA_FROM_L2_READY_INS out 1, DATA_FROM_L2_INS in WORD_PER_BLOCK*DATA_WIDTH: full-line refill, word 0 in LSBs.

Function
REQ-016 SHALL implement states IDLE, MISS_REQ, MISS_WAIT, REPLAY, FLUSH.
REQ-017 SHALL accept a PC when PC_VALID & READY & !STALL & !FLUSH; READY SHALL be high only in IDLE.
REQ-018 SHALL on hit present the word at INSTRUCTION with INSTRUCTION_VALID=1 the cycle after acceptance (1-cycle latency, back-to-back hits every cycle).
REQ-019 SHALL hit when any way of set PC[SO+WO+BO-1:WO+BO] is valid with tag PC[ADDRESS_WIDTH-1:ADDRESS_WIDTH-TAG]; tags are unique per set by construction.
REQ-020 SHALL on miss drop INSTRUCTION_VALID and READY the following cycle, latch PC, enter MISS_REQ.
REQ-021 SHALL in MISS_REQ hold ADDRESS_TO_L2_VALID_INS=1 and ADDRESS_TO_L2_INS=PC[ADDRESS_WIDTH-1:WO+BO] stable until ADDRESS_TO_L2_READY_INS=1, then enter MISS_WAIT.
REQ-022 SHALL in MISS_WAIT drive DATA_FROM_L2_READY_INS=1 (0 in all other states); on DATA_FROM_L2_VALID_INS write line, tag and valid into victim way, enter REPLAY.
REQ-023 SHALL select victim: lowest-index invalid way; else the set's round-robin pointer, which then increments modulo WAYS (pointer unchanged when an invalid way is used).
REQ-024 SHALL in REPLAY re-look-up the latched PC (guaranteed hit), output it as REQ-018, return to IDLE.
REQ-025 SHALL while STALL_INSTRUCTION_CACHE=1 hold INSTRUCTION and INSTRUCTION_VALID unchanged and accept no PC; MISS_REQ/MISS_WAIT continue; REPLAY waits until stall clears.
REQ-026 SHALL on FLUSH in IDLE enter FLUSH, clearing valid bits and round-robin pointers of one set per cycle from set 0 to SETS-1 (SETS cycles), INSTRUCTION_VALID=0, then IDLE.
REQ-027 SHALL give FLUSH priority over a same-cycle PC (PC not accepted); FLUSH arriving in MISS_REQ/MISS_WAIT/REPLAY SHALL be latched and serviced after REPLAY completes.
REQ-028 SHALL not raise ADDRESS_TO_L2_VALID_INS on a hit.

Reset
REQ-029 SHALL on RST asynchronously enter IDLE, clear all valid bits, pointers and pending flush; READY=1, INSTRUCTION=0, INSTRUCTION_VALID=0, both L2 valid/ready outputs=0, ADDRESS_TO_L2_INS=0.
REQ-030 SHALL abandon any in-flight miss on RST; late L2 data afterwards SHALL be ignored (DATA_FROM_L2_READY_INS=0).

Verification (defaults: SETS=64, set stride 0x1000)
REQ-031 Cold miss PC=0x00001004, L2 returns word i = i -> ADDRESS_TO_L2_INS=0x40, INSTRUCTION=0x1 after REPLAY; then PC=0x00001008 -> INSTRUCTION=0x2 next cycle, no L2 request.
REQ-032 Fill 0x0,0x1000,0x2000,0x3000 then 0x4000 -> 0x4000 evicts way 0; 0x1000 hits; 0x0 misses and evicts way 1 (0x1000 line).
REQ-033 ADDRESS_TO_L2_READY_INS low 5 cycles during miss -> VALID held 6 cycles, ADDRESS_TO_L2_INS constant.
REQ-034 FLUSH one cycle after fills -> READY low exactly 64 cycles; then PC=0x00001004 misses.
REQ-035 STALL high 3 cycles after hit -> INSTRUCTION/INSTRUCTION_VALID frozen, PC_VALID ignored; FLUSH during MISS_WAIT -> flush starts after REPLAY.
REQ-036 RST pulse in MISS_WAIT -> all outputs at REQ-029 values immediately; re-fetch of same PC misses.
